// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Holds the FSM state, grant owner and EX/MEM Mem-field encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // EX/MEM Mem field: bit1 = MemRead, bit0 = MemWrite
    localparam logic [1:0] CTL_NONE = 2'b00;
    localparam logic [1:0] CTL_WR   = 2'b01;
    localparam logic [1:0] CTL_RD   = 2'b10;
    localparam logic [1:0] CTL_RW   = 2'b11;

    // Wide enough for WAIT_CYCLES and STARVE_MAX up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: data port has priority unless instruction fetch has been
// passed over STARVE_MAX times in a row while it was waiting.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             if_req,
    input  logic             mem_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_t           owner
);

    logic if_forced;

    assign if_forced = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        owner = OWN_IF;
        if (mem_req && !if_forced) begin
            owner = OWN_MEM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and the MEM stage onto one fixed-latency
// single-port memory. Define MEM_ARB_CHECK_EN to add the sticky err_flag output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic [1:0]        mem_ctl,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_CHECK_EN
    ,
    output logic              err_flag
`endif
);

    state_t            state_reg, state_next;
    owner_t            owner_reg, pick_owner;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              we_reg;
    logic [CNT_W-1:0]  wait_reg;
    logic [CNT_W-1:0]  starve_reg;

    logic wr_req;
    logic mem_req;
    logic any_req;
    logic grant;
    logic grant_mem;

    assign wr_req    = (mem_ctl == CTL_WR) || (mem_ctl == CTL_RW);
    assign mem_req   = wr_req || (mem_ctl == CTL_RD);
    assign any_req   = mem_req || if_req;
    assign grant     = (state_reg == IDLE) && any_req;
    assign grant_mem = grant && (pick_owner == OWN_MEM);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .starve_cnt (starve_reg),
        .owner      (pick_owner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (wait_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant latch, wait/starvation counters and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg  <= OWN_IF;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            we_reg     <= 1'b0;
            wait_reg   <= '0;
            starve_reg <= '0;
        end else if (grant) begin
            owner_reg <= pick_owner;
            wait_reg  <= CNT_W'(WAIT_CYCLES - 1);
            if (pick_owner == OWN_MEM) begin
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
                we_reg    <= wr_req;
                if (if_req && (starve_reg != CNT_W'(STARVE_MAX))) begin
                    starve_reg <= starve_reg + 1'b1;
                end
            end else begin
                addr_reg   <= if_addr;
                wdata_reg  <= '0;
                we_reg     <= 1'b0;
                starve_reg <= '0;
            end
        end else if (state_reg == ACCESS) begin
            if (wait_reg == '0) begin
                rdata_reg <= ram_rdata;
            end else begin
                wait_reg <= wait_reg - 1'b1;
            end
        end
    end

    // Outputs decode from registered state only, so ram_rdata never reaches them combinationally
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        unique case (state_reg)
            ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = we_reg;
                ram_addr  = addr_reg;
                ram_wdata = wdata_reg;
            end
            DONE: begin
                if_ready  = (owner_reg == OWN_IF);
                mem_ready = (owner_reg == OWN_MEM);
            end
            default: ;
        endcase
    end

    assign if_rdata  = rdata_reg;
    assign mem_rdata = rdata_reg;
    assign stall_mem = (mem_ctl != CTL_NONE) && !mem_ready;
    assign stall_if  = if_req && !if_ready;

`ifdef MEM_ARB_CHECK_EN
    // Sticky: flags read-and-write encodings and misaligned data addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if (grant_mem && ((mem_ctl == CTL_RW) || (mem_addr[1:0] != 2'b00))) begin
            err_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WAIT_CYCLES=2, STARVE_MAX=4).
// Define MEM_ARB_CHECK_EN to also exercise err_flag.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [1:0]  mem_ctl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef MEM_ARB_CHECK_EN
    logic        err_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory stub: fixed word at 0x10, otherwise address folded with a marker
    assign ram_rdata = (ram_addr == 32'h10) ? 32'hDEADBEEF : (ram_addr ^ 32'h5A5A0000);

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .WAIT_CYCLES (2),
        .STARVE_MAX  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_ctl   (mem_ctl),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef MEM_ARB_CHECK_EN
        ,
        .err_flag  (err_flag)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_if;

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_ctl   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        #2;
        check("rst_ram_en",   {31'd0, ram_en},    32'd0);
        check("rst_mem_ready",{31'd0, mem_ready}, 32'd0);
        check("rst_if_ready", {31'd0, if_ready},  32'd0);
        check("rst_rdata",    mem_rdata,          32'd0);
        check("rst_stall",    {30'd0, stall_if, stall_mem}, 32'd0);
`ifdef MEM_ARB_CHECK_EN
        check("rst_err", {31'd0, err_flag}, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Data read at 0x10: ready three cycles after the request
        mem_ctl = 2'b10; mem_addr = 32'h10;
        #1;
        check("rd_stall_n0", {31'd0, stall_mem}, 32'd1);
        check("rd_ready_n0", {31'd0, mem_ready}, 32'd0);
        tick();
        check("rd_ram_en_n1", {31'd0, ram_en}, 32'd1);
        check("rd_ram_we_n1", {31'd0, ram_we}, 32'd0);
        check("rd_ram_addr_n1", ram_addr, 32'h10);
        check("rd_stall_n1", {31'd0, stall_mem}, 32'd1);
        tick();
        check("rd_stall_n2", {31'd0, stall_mem}, 32'd1);
        check("rd_ready_n2", {31'd0, mem_ready}, 32'd0);
        tick();
        check("rd_ready_n3", {31'd0, mem_ready}, 32'd1);
        check("rd_rdata_n3", mem_rdata, 32'hDEADBEEF);
        check("rd_stall_n3", {31'd0, stall_mem}, 32'd0);
        check("rd_ram_en_n3", {31'd0, ram_en}, 32'd0);
        $display("txn read  addr=00000010 data=%08h", mem_rdata);
        mem_ctl = 2'b00;
        tick();
        check("rd_ready_n4", {31'd0, mem_ready}, 32'd0);

        // Data write at 0x20
        mem_ctl = 2'b01; mem_addr = 32'h20; mem_wdata = 32'h1234;
        tick();
        check("wr_ram_en", {31'd0, ram_en}, 32'd1);
        check("wr_ram_we", {31'd0, ram_we}, 32'd1);
        check("wr_ram_addr", ram_addr, 32'h20);
        check("wr_ram_wdata", ram_wdata, 32'h1234);
        tick();
        check("wr_ram_we_n2", {31'd0, ram_we}, 32'd1);
        tick();
        check("wr_ready", {31'd0, mem_ready}, 32'd1);
        check("wr_if_ready", {31'd0, if_ready}, 32'd0);
        $display("txn write addr=00000020 data=00001234");
        mem_ctl = 2'b00;
        tick();
        check("wr_ready_once", {31'd0, mem_ready}, 32'd0);

        // Simultaneous requests: data first, IF ready at N+7
        if_req = 1'b1; if_addr = 32'h80; mem_ctl = 2'b10; mem_addr = 32'h40;
        #1;
        check("both_stall", {30'd0, stall_if, stall_mem}, 32'd3);
        tick();
        check("both_addr_mem", ram_addr, 32'h40);
        tick();
        tick();
        check("both_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("both_if_ready_n3", {31'd0, if_ready}, 32'd0);
        check("both_mem_rdata", mem_rdata, 32'h5A5A0040);
        $display("txn read  addr=00000040 data=%08h (data port)", mem_rdata);
        mem_ctl = 2'b00;
        tick();
        check("both_idle_ram_en", {31'd0, ram_en}, 32'd0);
        tick();
        check("both_addr_if", ram_addr, 32'h80);
        check("both_we_if", {31'd0, ram_we}, 32'd0);
        tick();
        tick();
        check("both_if_ready_n7", {31'd0, if_ready}, 32'd1);
        check("both_if_rdata", if_rdata, 32'h5A5A0080);
        check("both_stall_if_n7", {31'd0, stall_if}, 32'd0);
        $display("txn fetch addr=00000080 data=%08h", if_rdata);
        if_req = 1'b0;
        tick();
        check("both_if_ready_n8", {31'd0, if_ready}, 32'd0);

        // Starvation: four data grants, then IF forced, then the pattern repeats
        if_req = 1'b1; if_addr = 32'h80; mem_ctl = 2'b10; mem_addr = 32'h40;
        for (int g = 0; g < 10; g++) begin
            exp_if = (g == 4) || (g == 9);
            tick();
            tick();
            tick();
            check($sformatf("starve_if_ready_g%0d", g),  {31'd0, if_ready},  {31'd0, exp_if});
            check($sformatf("starve_mem_ready_g%0d", g), {31'd0, mem_ready}, {31'd0, !exp_if});
            $display("txn grant %0d owner=%s", g, if_ready ? "IF" : "MEM");
            tick();
        end
        if_req = 1'b0; mem_ctl = 2'b00;
        tick();

        // Reset in the middle of an access
        mem_ctl = 2'b10; mem_addr = 32'h10;
        tick();
        check("pre_rst_ram_en", {31'd0, ram_en}, 32'd1);
        rst_n = 1'b0; mem_ctl = 2'b00;
        #1;
        check("arst_ram_en", {31'd0, ram_en}, 32'd0);
        check("arst_ram_addr", ram_addr, 32'd0);
        check("arst_rdata", mem_rdata, 32'd0);
        check("arst_stall", {31'd0, stall_mem}, 32'd0);
        tick();
        tick();
        check("arst_no_ready", {30'd0, if_ready, mem_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_no_ready", {30'd0, if_ready, mem_ready}, 32'd0);
        mem_ctl = 2'b10; mem_addr = 32'h40;
        tick();
        tick();
        tick();
        check("post_rst_ready", {31'd0, mem_ready}, 32'd1);
        check("post_rst_rdata", mem_rdata, 32'h5A5A0040);
        $display("txn read  addr=00000040 data=%08h (after reset)", mem_rdata);
        mem_ctl = 2'b00;
        tick();

`ifdef MEM_ARB_CHECK_EN
        // Misaligned read sets a sticky error
        check("err_clear", {31'd0, err_flag}, 32'd0);
        mem_ctl = 2'b10; mem_addr = 32'h22;
        tick();
        check("err_set", {31'd0, err_flag}, 32'd1);
        tick();
        tick();
        check("err_access_done", {31'd0, mem_ready}, 32'd1);
        mem_ctl = 2'b00;
        tick();
        mem_ctl = 2'b10; mem_addr = 32'h40;
        tick();
        tick();
        tick();
        check("err_sticky", {31'd0, err_flag}, 32'd1);
        mem_ctl = 2'b00;
        tick();
        rst_n = 1'b0;
        #1;
        check("err_reset", {31'd0, err_flag}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between instruction fetch (IF) and the MEM stage.
- The MEM stage request is driven from the EX/MEM register outputs (Mem control, ALU address, store data).
- Arbitrates the two requesters, sequences each access through a fixed-latency memory, and returns read data.
- Raises stall signals so the pipeline freezes while a requester waits.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, memory read latency in cycles; legal range 1..15.
- STARVE_MAX, 4, consecutive data grants tolerated while IF waits, before IF is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_ctl  in  2  EX/MEM Mem field; bit1=MemRead, bit0=MemWrite; 00 = no access.
- mem_addr  in  ADDR_W  data address (EX/MEM ALU result).
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid when mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for the data port.
- stall_if  out  1  freeze PC/IF.
- stall_mem  out  1  freeze EX/MEM and earlier stages.
- ram_en  out  1  memory enable.
- ram_we  out  1  memory write enable.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State returns to IDLE; starvation counter and wait counter clear to 0.
  - All outputs go to 0.
  - An access in flight is abandoned and no ready pulse is issued for it.
- States:
  - IDLE -> ACCESS when a request is pending.
  - ACCESS -> DONE when the wait counter reaches 0.
  - DONE -> IDLE unconditionally.
- Arbitration (IDLE only):
  - Data request (mem_ctl != 00) beats if_req, unless starve_cnt == STARVE_MAX and if_req=1; then IF wins.
  - starve_cnt increments (saturating) on each data grant made while if_req=1; clears on every IF grant.
- On grant: latch address, write data, write flag and grant owner.
  - mem_ctl=11 is treated as a write.
  - Load the wait counter with WAIT_CYCLES-1.
- ACCESS:
  - ram_en=1 and ram_addr/ram_wdata/ram_we come from the latched values; ram_we=0 for IF.
  - The wait counter decrements each cycle.
  - At counter 0, ram_rdata is valid and is captured.
- DONE:
  - The granted port's ready pulses for exactly 1 cycle; rdata holds the captured word (undefined content for writes).
  - ram_en=0.
- Latency: request seen in IDLE at cycle N gives ready at cycle N+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- Requester contract: hold the request stable until ready. A request withdrawn mid-access still completes and still pulses ready; the requester ignores the pulse.
- Stalls (combinational):
  - stall_mem = (mem_ctl != 00) & ~mem_ready.
  - stall_if = if_req & ~if_ready.
- No combinational path from ram_rdata to any output.

Optional Feature:
- MEM_ARB_CHECK_EN defined:
  - Adds output err_flag (1 bit).
  - err_flag is sticky; it is set when a data grant sees mem_ctl=11 or mem_addr[1:0] != 0, and cleared only by reset.
  - The access still proceeds as described above.
- Undefined: no err_flag port and no checking logic.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE/ACCESS/DONE).
  - Owner enum (OWN_IF/OWN_MEM).
  - mem_ctl encoding constants (CTL_NONE, CTL_WR, CTL_RD, CTL_RW).
- Sub-module mem_arb_pick: combinational priority plus starvation grant decision; inputs are the requests and starve_cnt, output is the owner.

Test Plan:
- WAIT_CYCLES=2, mem_ctl=10, mem_addr=0x10, memory returns 0xDEADBEEF -> mem_ready pulse at N+3 with mem_rdata=0xDEADBEEF; stall_mem=1 in N..N+2.
- mem_ctl=01, addr 0x20, wdata 0x00001234 -> during ACCESS ram_en=1, ram_we=1, ram_addr=0x20, ram_wdata=0x1234; mem_ready pulses once.
- if_req and mem_ctl=10 raised in the same cycle -> data served first (mem_ready at N+3); IF granted in the next IDLE, if_ready at N+7 (WAIT_CYCLES=2).
- STARVE_MAX=4, continuous data requests and if_req=1 -> first 4 grants go to data, 5th grant to IF; starve_cnt returns to 0.
- rst_n low during ACCESS -> all outputs 0 immediately, no ready pulse; after release a new read at 0x40 completes normally.
- With MEM_ARB_CHECK_EN, data read at addr 0x22 -> err_flag=1 and stays 1 through later legal accesses; it clears only on reset.
